mac_accumulator: RTL and testbench
==================================

# mac_accumulator

Fixed-point multiply-accumulate stage for the FIR/CNN datapath. It accepts a stream of (data, weight) pairs over a valid/ready handshake and accumulates `N_TAPS` products onto a per-frame bias. It presents one result per frame as a `WORD_SIZE`-bit sum plus a carry-out bit. It sits directly upstream of the overflow detector, and its `sum_n`/`sum_carry_out` pair follows that block's encoding: {carry, msb} = 01 means overflow, 10 means underflow.

## Interface
- `WORD_SIZE`, 16: bits per data/weight/bias/sum word (signed two's complement).
- `INT_BITS`, 8: integer bits including sign. FRAC = `WORD_SIZE`-`INT_BITS`.
- `N_TAPS`, 8: products per frame, ≥2.

- `clk_i` input 1: clock. One clock only; all state updates on its rising edge.
- `reset_i` input 1: synchronous, active-high reset.
- `valid_i` input 1: input beat valid.
- `ready_o` output 1: input beat accepted when `valid_i` and `ready_o` are both high.
- `data_i` input `WORD_SIZE`: signed Q(INT_BITS).(FRAC) data.
- `weight_i` input `WORD_SIZE`: signed Q-format weight.
- `bias_i` input `WORD_SIZE`: signed bias, sampled on the first beat of each frame.
- `valid_o` output 1: result valid.
- `ready_i` input 1: downstream accepts the result.
- `sum_n` output `WORD_SIZE`: low `WORD_SIZE` bits of the 17-bit (`WORD_SIZE`+1) clamped accumulator.
- `sum_carry_out` output 1: bit `WORD_SIZE` of the accumulator.

## Operation
- **Product**
  - Full signed product is 2·`WORD_SIZE` bits.
  - Arithmetic shift right by FRAC; truncation rounds toward −∞.
  - Clamp to the signed `WORD_SIZE`+1 range [−2^WORD_SIZE, 2^WORD_SIZE−1].
  - Result is registered in stage 1, together with first/last tags.
- **Accumulate (stage 2)**
  - acc_next = (first ? sign-extended bias : acc) + product, computed at `WORD_SIZE`+2 bits.
  - The sum is clamped to the `WORD_SIZE`+1 range and registered.
  - An out-of-16-bit-range result therefore always reads as {carry, msb} = 01 (positive) or 10 (negative).
  - A clamped accumulator may recover if later taps bring it back in range.
- **Tap counter**
  - Counts 0..`N_TAPS`−1 and increments on each accepted beat.
  - count==0 tags the beat first; count==`N_TAPS`−1 tags it last and wraps the counter to 0.
- **FSM states**
  - IDLE: `ready_o`=1. An accepted beat moves to ACCUM, or to DRAIN if it is last (not possible since `N_TAPS`≥2).
  - ACCUM: `ready_o`=1. An accepted last beat moves to DRAIN.
  - DRAIN: `ready_o`=0. Waits one cycle for the last product to accumulate, then moves to DONE.
  - DONE: `valid_o`=1, `ready_o`=0. When `ready_i`=1, moves to IDLE.
- `valid_i` low in IDLE/ACCUM stalls accumulation; no bubble products are added.
- `sum_n`/`sum_carry_out` hold the last accumulator value at all times. They are stable while `valid_o`=1.
- `ready_o` is combinational from state and is forced 0 while `reset_i`=1.

## Timing
- **Reset** (any state, including mid-frame or while in DONE): on the next edge state=IDLE, tap count=0, acc=0, stage-1 tags cleared.
  - Output reset values: `valid_o`=0, `sum_n`=0, `sum_carry_out`=0.
  - `ready_o`=0 during reset and 1 in the first cycle after it.
  - A partial frame is discarded.
- **Latency**
  - Last beat accepted at edge k; product registered at k; accumulator updated at k+1.
  - `valid_o` goes high after edge k+1, so it is visible 2 cycles after the accept cycle.
- **Throughput**: min `N_TAPS`+2 cycles per frame when `ready_i` is held high. The result handshake and the return to IDLE occur on the same edge, and the next frame's first beat is accepted the cycle after.
- **Backpressure**: `valid_o` stays high and outputs stay stable indefinitely until `ready_i`. No input beats are accepted meanwhile.
- `ready_i` high outside DONE has no effect.

## Configuration
- `MAC_ROUND_EN` defined: add 2^(FRAC−1) to the full product before the shift, i.e. round half up (toward +∞) to nearest.
- Undefined: plain arithmetic-shift truncation (floor).
- Clamping, handshake and latency are identical in both builds.

## Test plan
All vectors use `WORD_SIZE`=16, `INT_BITS`=8, `N_TAPS`=4; 1.0 = 0x0100.
- **Basic sum**: bias 0x0000, data 0x0100 ×4, weights 0x0100, 0x0200, 0xFF00, 0x0080 → `sum_n`=0x0280, carry 0, `valid_o` high 2 cycles after the last accept.
- **Overflow clamp**: bias 0, data 0x7F00 ×4, weight 0x0100 ×4 → `sum_n`=0xFFFF, carry 0 (pattern 01).
- **Underflow clamp**: bias 0, data 0x8000 ×4, weight 0x0100 ×4 → `sum_n`=0x0000, carry 1 (pattern 10).
- **Rounding**: data 0x0001, weight 0x0080 ×4, bias 0 → 0x0000 without `MAC_ROUND_EN`, 0x0004 with it.
  - Data 0x0001, weight 0xFF80 ×4 → 0xFFFC, carry 1 without `MAC_ROUND_EN`.
- **Backpressure**: hold `ready_i` low 5 cycles after `valid_o` rises, keep `valid_i` high → `ready_o`=0 throughout, no beats accepted, `sum_n` stable. Release → next frame's first beat accepted the following cycle.
- **Reset mid-frame**: accept 2 beats, pulse `reset_i` → `valid_o`=0, `ready_o`=1 next cycle. A fresh 4-beat frame then yields only its own sum (e.g. the basic-sum vector gives 0x0280).

Source files
------------

// File: rtl/mac_accumulator.sv
// mac_accumulator - fixed-point multiply-accumulate stage for the FIR/CNN datapath.
//
// Accepts (data, weight) beats over valid/ready. It accumulates N_TAPS clamped
// products onto the bias that arrives with the first beat of the frame. One
// result per frame is presented as a WORD_SIZE-bit sum plus a carry bit.
// {sum_carry_out, sum_n[msb]} = 01 flags overflow and 10 flags underflow for the
// downstream overflow detector.
//
// Build option: define MAC_ROUND_EN to round each product half-up to nearest
// before the fractional shift. When it is undefined the shift truncates (floor).
//
// Ports
//   clk_i          : clock, rising edge
//   reset_i        : synchronous active-high reset
//   valid_i/ready_o: input beat handshake
//   data_i         : signed Q(INT_BITS).(FRAC) data
//   weight_i       : signed Q-format weight
//   bias_i         : signed bias, taken on the first beat of a frame
//   valid_o/ready_i: result handshake
//   sum_n          : low WORD_SIZE bits of the clamped accumulator
//   sum_carry_out  : bit WORD_SIZE of the clamped accumulator

module mac_accumulator #(
  parameter int WORD_SIZE = 16,
  parameter int INT_BITS  = 8,
  parameter int N_TAPS    = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [WORD_SIZE-1:0] data_i,
  input  logic [WORD_SIZE-1:0] weight_i,
  input  logic [WORD_SIZE-1:0] bias_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [WORD_SIZE-1:0] sum_n,
  output logic                 sum_carry_out
);

  // state | meaning
  // IDLE  | waiting for the first beat of a frame
  // ACCUM | mid-frame, accepting beats
  // DRAIN | last product registered, accumulator catching up
  // DONE  | result valid, waiting for ready_i

  localparam int FRAC = WORD_SIZE - INT_BITS;
  localparam int PFW  = 2 * WORD_SIZE;      // full product
  localparam int PW   = 2 * WORD_SIZE + 1;  // product plus rounding headroom
  localparam int AW   = WORD_SIZE + 2;      // accumulator adder width
  localparam int CW   = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;

  localparam logic signed [PW-1:0] P_MAX = {{(PW-WORD_SIZE){1'b0}}, {WORD_SIZE{1'b1}}};
  localparam logic signed [PW-1:0] P_MIN = {{(PW-WORD_SIZE){1'b1}}, {WORD_SIZE{1'b0}}};
  localparam logic signed [AW-1:0] A_MAX = {2'b00, {WORD_SIZE{1'b1}}};
  localparam logic signed [AW-1:0] A_MIN = {2'b11, {WORD_SIZE{1'b0}}};
  localparam logic signed [WORD_SIZE:0] S_MAX = {1'b0, {WORD_SIZE{1'b1}}};
  localparam logic signed [WORD_SIZE:0] S_MIN = {1'b1, {WORD_SIZE{1'b0}}};
`ifdef MAC_ROUND_EN
  localparam logic signed [PW-1:0] HALF = PW'(1) << (FRAC - 1);
`endif

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t                     state;
  logic [CW-1:0]              count;
  logic                       accept;
  logic                       first;
  logic                       last;

  logic signed [PFW-1:0]      prod_full;
  logic signed [PW-1:0]       prod_rnd;
  logic signed [PW-1:0]       prod_shift;
  logic signed [WORD_SIZE:0]  prod_clamp;

  logic                       pvld_q;
  logic                       first_q;
  logic                       last_q;
  logic signed [WORD_SIZE:0]  prod_q;
  logic [WORD_SIZE-1:0]       bias_q;

  logic signed [AW-1:0]       acc_base;
  logic signed [AW-1:0]       acc_sum;
  logic signed [WORD_SIZE:0]  acc_clamp;
  logic signed [WORD_SIZE:0]  acc;

  assign ready_o = !reset_i && (state == IDLE || state == ACCUM);
  assign accept  = valid_i && ready_o;
  assign first   = (count == '0);
  assign last    = (count == CW'(N_TAPS - 1));

  always_comb begin
    prod_full = PFW'($signed(data_i)) * PFW'($signed(weight_i));
`ifdef MAC_ROUND_EN
    prod_rnd  = PW'(prod_full) + HALF;
`else
    prod_rnd  = PW'(prod_full);
`endif
    // Arithmetic shift of a two's complement value floors toward -inf.
    prod_shift = prod_rnd >>> FRAC;
    if (prod_shift > P_MAX)      prod_clamp = S_MAX;
    else if (prod_shift < P_MIN) prod_clamp = S_MIN;
    else                         prod_clamp = prod_shift[WORD_SIZE:0];
  end

  always_comb begin
    acc_base = first_q ? AW'($signed(bias_q)) : AW'(acc);
    acc_sum  = acc_base + AW'(prod_q);
    if (acc_sum > A_MAX)      acc_clamp = S_MAX;
    else if (acc_sum < A_MIN) acc_clamp = S_MIN;
    else                      acc_clamp = acc_sum[WORD_SIZE:0];
  end

  // Stage 1: clamped product with frame position tags.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pvld_q  <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      prod_q  <= '0;
      bias_q  <= '0;
    end else begin
      pvld_q  <= accept;
      first_q <= accept && first;
      last_q  <= accept && last;
      if (accept) begin
        prod_q <= prod_clamp;
        bias_q <= bias_i;
      end
    end
  end

  // Stage 2: accumulator only moves on a real product, never on a bubble.
  always_ff @(posedge clk_i) begin
    if (reset_i)     acc <= '0;
    else if (pvld_q) acc <= acc_clamp;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= IDLE;
      count   <= '0;
      valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            count <= last ? '0 : count + 1'b1;
            state <= last ? DRAIN : ACCUM;
          end
        end
        DRAIN: begin
          // last_q marks the cycle the final product enters the accumulator.
          if (last_q) begin
            state   <= DONE;
            valid_o <= 1'b1;
          end
        end
        DONE: begin
          if (ready_i) begin
            state   <= IDLE;
            valid_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sum_n         = acc[WORD_SIZE-1:0];
  assign sum_carry_out = acc[WORD_SIZE];

endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator - directed bench for mac_accumulator with N_TAPS=4 and Q8.8 data.
module tb_mac_accumulator;
  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] data_i;
  logic [15:0] weight_i;
  logic [15:0] bias_i;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] sum_n;
  logic        sum_carry_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  mac_accumulator #(.WORD_SIZE(16), .INT_BITS(8), .N_TAPS(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .weight_i(weight_i), .bias_i(bias_i), .valid_o(valid_o),
    .ready_i(ready_i), .sum_n(sum_n), .sum_carry_out(sum_carry_out)
  );

  // Beat i uses dv/wv[16*i +: 16].
  task automatic send_frame(input logic [15:0] bias, input logic [63:0] dv, input logic [63:0] wv,
                            output int first_cyc, output int last_cyc, output int first_wait);
    int n;
    first_cyc = 0; last_cyc = 0; first_wait = 0;
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1; bias_i = bias; data_i = dv[16*i +: 16]; weight_i = wv[16*i +: 16];
      n = 0;
      while (!ready_o && n < 100) begin @(posedge clk_i); #1; n++; end
      if (i == 0) first_wait = n;
      @(posedge clk_i); #1;
      if (i == 0) first_cyc = cyc;
      if (i == 3) last_cyc = cyc;
    end
    valid_i = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid_o && n < 50) begin @(posedge clk_i); #1; n++; end
  endtask

  task automatic take_result();
    ready_i = 1'b1; @(posedge clk_i); #1; ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    data_i = '0; weight_i = '0; bias_i = '0;
    repeat (2) @(posedge clk_i); #1;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    checks++; if ({sum_carry_out, sum_n} !== 17'h0) begin errors++; $display("FAIL reset_sum: got %h want 00000", {sum_carry_out, sum_n}); end
    reset_i = 1'b0; #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", ready_o); end
  endtask

  task automatic test_basic();
    int fc, lc, fw, n;
    send_frame(16'h0000, {4{16'h0100}}, {16'h0080, 16'hFF00, 16'h0200, 16'h0100}, fc, lc, fw);
    wait_valid(n);
    checks++; if (n !== 1) begin errors++; $display("FAIL basic_latency: got %0d edges want 1", n); end
    checks++; if (sum_n !== 16'h0280) begin errors++; $display("FAIL basic_sum: got %h want 0280", sum_n); end
    checks++; if (sum_carry_out !== 1'b0) begin errors++; $display("FAIL basic_carry: got %b want 0", sum_carry_out); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL basic_ready_done: got %b want 0", ready_o); end
    take_result();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b want 0", valid_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL basic_ready_idle: got %b want 1", ready_o); end
  endtask

  // overflow, underflow, recovery after clamp, per-product clamp, bias
  task automatic test_clamp();
    logic [15:0] b [5];
    logic [63:0] d [5];
    logic [63:0] w [5];
    logic [16:0] e [5];
    int fc, lc, fw, n;
    b[0] = 16'h0000; d[0] = {4{16'h7F00}}; w[0] = {4{16'h0100}}; e[0] = 17'h0FFFF;
    b[1] = 16'h0000; d[1] = {4{16'h8000}}; w[1] = {4{16'h0100}}; e[1] = 17'h10000;
    b[2] = 16'h0000; d[2] = {4{16'h7F00}}; w[2] = {16'hFE00, 16'h0100, 16'h0100, 16'h0100}; e[2] = 17'h001FF;
    b[3] = 16'h0000; d[3] = {16'h0000, 16'h0100, 16'h8000, 16'h7FFF};
    w[3] = {16'h0000, 16'h0100, 16'h7FFF, 16'h7FFF}; e[3] = 17'h000FF;
    b[4] = 16'h0100; d[4] = {4{16'h0100}}; w[4] = {4{16'h0100}}; e[4] = 17'h00500;
    for (int t = 0; t < 5; t++) begin
      send_frame(b[t], d[t], w[t], fc, lc, fw);
      wait_valid(n);
      checks++;
      if (valid_o !== 1'b1 || {sum_carry_out, sum_n} !== e[t]) begin
        errors++; $display("FAIL clamp_case%0d: got valid=%b %h want valid=1 %h", t, valid_o, {sum_carry_out, sum_n}, e[t]);
      end
      take_result();
    end
  endtask

  task automatic test_rounding();
    int fc, lc, fw, n;
    logic [16:0] e_pos, e_neg;
`ifdef MAC_ROUND_EN
    e_pos = 17'h00004; e_neg = 17'h00000;
`else
    e_pos = 17'h00000; e_neg = 17'h1FFFC;
`endif
    send_frame(16'h0000, {4{16'h0001}}, {4{16'h0080}}, fc, lc, fw);
    wait_valid(n);
    checks++; if ({sum_carry_out, sum_n} !== e_pos) begin errors++; $display("FAIL round_pos: got %h want %h", {sum_carry_out, sum_n}, e_pos); end
    take_result();
    send_frame(16'h0000, {4{16'h0001}}, {4{16'hFF80}}, fc, lc, fw);
    wait_valid(n);
    checks++; if ({sum_carry_out, sum_n} !== e_neg) begin errors++; $display("FAIL round_neg: got %h want %h", {sum_carry_out, sum_n}, e_neg); end
    take_result();
  endtask

  task automatic test_backpressure();
    int fc, lc, fw, n, rel;
    send_frame(16'h0000, {4{16'h0100}}, {16'h0080, 16'hFF00, 16'h0200, 16'h0100}, fc, lc, fw);
    wait_valid(n);
    valid_i = 1'b1; bias_i = 16'h0100; data_i = 16'h0100; weight_i = 16'h0100;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      checks++;
      if (ready_o !== 1'b0 || valid_o !== 1'b1 || sum_n !== 16'h0280) begin
        errors++; $display("FAIL bp_hold%0d: got ready=%b valid=%b sum=%h want 0 1 0280", i, ready_o, valid_o, sum_n);
      end
    end
    take_result();
    rel = cyc;
    checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin errors++; $display("FAIL bp_release: got ready=%b valid=%b want 1 0", ready_o, valid_o); end
    send_frame(16'h0100, {4{16'h0100}}, {4{16'h0100}}, fc, lc, fw);
    checks++; if (fc !== rel + 1) begin errors++; $display("FAIL bp_first_accept: got cycle %0d want %0d", fc, rel + 1); end
    wait_valid(n);
    checks++; if ({sum_carry_out, sum_n} !== 17'h00500) begin errors++; $display("FAIL bp_next_sum: got %h want 00500", {sum_carry_out, sum_n}); end
    take_result();
  endtask

  task automatic test_back_to_back();
    int fca, lca, fwa, fcb, lcb, fwb, n;
    ready_i = 1'b1;
    send_frame(16'h0000, {4{16'h0100}}, {16'h0080, 16'hFF00, 16'h0200, 16'h0100}, fca, lca, fwa);
    send_frame(16'h0100, {4{16'h0100}}, {4{16'h0100}}, fcb, lcb, fwb);
    checks++; if (fcb - fca !== 6) begin errors++; $display("FAIL b2b_period: got %0d cycles want 6", fcb - fca); end
    wait_valid(n);
    checks++; if (n !== 1 || sum_n !== 16'h0500) begin errors++; $display("FAIL b2b_sum: got n=%0d sum=%h want 1 0500", n, sum_n); end
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop: got %b want 0", valid_o); end
  endtask

  task automatic test_reset_mid();
    int fc, lc, fw, n;
    valid_i = 1'b1; bias_i = 16'h0700; data_i = 16'h0100; weight_i = 16'h0100;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    valid_i = 1'b0; reset_i = 1'b1; #1;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL midrst_ready_low: got %b want 0", ready_o); end
    @(posedge clk_i); #1;
    reset_i = 1'b0; #1;
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL midrst_after: got valid=%b ready=%b want 0 1", valid_o, ready_o); end
    send_frame(16'h0000, {4{16'h0100}}, {16'h0080, 16'hFF00, 16'h0200, 16'h0100}, fc, lc, fw);
    wait_valid(n);
    checks++; if (n !== 1 || {sum_carry_out, sum_n} !== 17'h00280) begin errors++; $display("FAIL midrst_fresh_sum: got n=%0d %h want 1 00280", n, {sum_carry_out, sum_n}); end
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0; #1;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || {sum_carry_out, sum_n} !== 17'h0) begin
      errors++; $display("FAIL done_reset: got valid=%b ready=%b sum=%h want 0 1 00000", valid_o, ready_o, {sum_carry_out, sum_n});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_rounding();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
